// File: rtl/wb_stage_seq_if.sv
// Bundle of memory-stage handshake, load-response and register-file write signals
// for wb_stage_seq; slave is the stage's view, master the surrounding pipeline's.
interface wb_stage_seq_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  alu;
  logic [WIDTH-1:0]  csr_rdata;
  logic [WIDTH-1:0]  pc;
  logic [1:0]        wb_sel;
  logic              reg_wr;
  logic [REG_AW-1:0] rd_addr;
  logic [2:0]        load_size;
  logic [2:0]        addr_lsb;
  logic              dmem_rvalid;
  logic [WIDTH-1:0]  dmem_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [WIDTH-1:0]  rf_wdata;
  logic              stall_o;
  logic [63:0]       instret_o;

  modport slave (
    input  in_valid, alu, csr_rdata, pc, wb_sel, reg_wr, rd_addr,
           load_size, addr_lsb, dmem_rvalid, dmem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, stall_o, instret_o
  );

  modport master (
    output in_valid, alu, csr_rdata, pc, wb_sel, reg_wr, rd_addr,
           load_size, addr_lsb, dmem_rvalid, dmem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, stall_o, instret_o
  );
endinterface

// File: rtl/wb_stage_seq.sv
// Registered write-back stage: result select, load wait/stall, RF write port, instret.
// Define WB_LOAD_EXT_EN to shift/size/extend load data here instead of in the memory unit.
module wb_stage_seq #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input logic           clk,
  input logic           rst_n,
  wb_stage_seq_if.slave bus
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t            state, state_nxt;
  logic              transfer, is_load, complete;
  logic              we_nxt;
  logic [REG_AW-1:0] waddr_nxt;
  logic [WIDTH-1:0]  wdata_nxt, load_data;
  logic              cap_reg_wr;
  logic [REG_AW-1:0] cap_rd;

`ifdef WB_LOAD_EXT_EN
  logic [2:0] cap_size, cap_lsb;

  function automatic logic [WIDTH-1:0] load_result(input logic [WIDTH-1:0] raw,
                                                   input logic [2:0] size,
                                                   input logic [2:0] lsb);
    logic [WIDTH-1:0] sh, res;
    logic [5:0]       shamt;
    shamt = (WIDTH == 32) ? {1'b0, lsb[1:0], 3'b000} : {lsb, 3'b000};
    sh    = raw >> shamt;
    res   = sh;
    // At WIDTH=32 the 32-bit sign/zero extensions reduce to identity.
    case (size)
      3'b000: begin res = {WIDTH{sh[7]}};  res[7:0]  = sh[7:0];  end
      3'b001: begin res = {WIDTH{sh[15]}}; res[15:0] = sh[15:0]; end
      3'b010: begin res = {WIDTH{sh[31]}}; res[31:0] = sh[31:0]; end
      3'b100: begin res = '0; res[7:0]  = sh[7:0];  end
      3'b101: begin res = '0; res[15:0] = sh[15:0]; end
      3'b110: begin res = '0; res[31:0] = sh[31:0]; end
      default: res = sh;
    endcase
    return res;
  endfunction

  always_comb begin
    if (state == WAIT_LOAD) load_data = load_result(bus.dmem_rdata, cap_size, cap_lsb);
    else                    load_data = load_result(bus.dmem_rdata, bus.load_size, bus.addr_lsb);
  end
`else
  logic unused_ld;
  assign unused_ld = ^{bus.load_size, bus.addr_lsb};

  always_comb load_data = bus.dmem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (transfer && is_load && !bus.dmem_rvalid) state_nxt = WAIT_LOAD;
      WAIT_LOAD: if (bus.dmem_rvalid) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == IDLE);
    is_load      = (bus.wb_sel == 2'b01);
    transfer     = bus.in_valid && (state == IDLE);
    bus.stall_o  = (state == WAIT_LOAD) || (transfer && is_load && !bus.dmem_rvalid);
    complete     = (transfer && (!is_load || bus.dmem_rvalid))
                || ((state == WAIT_LOAD) && bus.dmem_rvalid);
    if (state == WAIT_LOAD) begin
      we_nxt    = cap_reg_wr && (cap_rd != '0);
      waddr_nxt = cap_rd;
      wdata_nxt = load_data;
    end else begin
      we_nxt    = bus.reg_wr && (bus.rd_addr != '0);
      waddr_nxt = bus.rd_addr;
      case (bus.wb_sel)
        2'b00:   wdata_nxt = bus.alu;
        2'b01:   wdata_nxt = load_data;
        2'b10:   wdata_nxt = bus.pc + WIDTH'(4);
        default: wdata_nxt = bus.csr_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_reg_wr <= 1'b0;
      cap_rd     <= '0;
`ifdef WB_LOAD_EXT_EN
      cap_size   <= '0;
      cap_lsb    <= '0;
`endif
    end else if (transfer && is_load && !bus.dmem_rvalid) begin
      cap_reg_wr <= bus.reg_wr;
      cap_rd     <= bus.rd_addr;
`ifdef WB_LOAD_EXT_EN
      cap_size   <= bus.load_size;
      cap_lsb    <= bus.addr_lsb;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      bus.instret_o <= '0;
    end else begin
      bus.rf_we <= complete && we_nxt;
      if (complete) begin
        bus.rf_waddr  <= waddr_nxt;
        bus.rf_wdata  <= wdata_nxt;
        bus.instret_o <= bus.instret_o + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_seq.sv
// Bench for wb_stage_seq: vector table plus hand sequences, scoreboard of expected RF writes.
module tb_wb_stage_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_stage_seq_if #(.WIDTH(32), .REG_AW(5)) bus ();

  wb_stage_seq #(.WIDTH(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef WB_LOAD_EXT_EN
  localparam logic [31:0] LHU_EXP = 32'h0000_8001;
  localparam logic [31:0] LB_EXP  = 32'h0000_007F;
  localparam logic [31:0] DLY_EXP = 32'hFFFF_FF80;
`else
  localparam logic [31:0] LHU_EXP = 32'h8001_0000;
  localparam logic [31:0] LB_EXP  = 32'h7F00_0000;
  localparam logic [31:0] DLY_EXP = 32'h0080_0000;
`endif

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] alu, csr, pc, rdata;
    logic        rv, reg_wr;
    logic [4:0]  rd;
    logic [2:0]  size, lsb;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_instret = '0, exp_instret = '0;
  logic [4:0]  hold_addr = '0;
  logic [31:0] hold_data = '0;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.we = we; e.waddr = a; e.wdata = d;
    sbq.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.dmem_rvalid = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.wb_sel = v.sel; bus.alu = v.alu; bus.csr_rdata = v.csr; bus.pc = v.pc;
    bus.dmem_rdata = v.rdata; bus.dmem_rvalid = v.rv; bus.reg_wr = v.reg_wr;
    bus.rd_addr = v.rd; bus.load_size = v.size; bus.addr_lsb = v.lsb;
    bus.in_valid = 1'b1;
    push(v.exp_we, v.rd, v.exp_wdata);
    step();
  endtask

  // Completion is recognised by a write strobe or an instret change.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      last_instret = '0; exp_instret = '0; hold_addr = '0; hold_data = '0;
    end else if (bus.rf_we || bus.instret_o != last_instret) begin
      if (sbq.size() == 0) begin
        chk("spurious_completion", {63'd0, bus.rf_we}, 64'd0);
        chk("spurious_instret", bus.instret_o, last_instret);
      end else begin
        e = sbq.pop_front();
        exp_instret = exp_instret + 64'd1;
        chk("rf_we", {63'd0, bus.rf_we}, {63'd0, e.we});
        chk("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, e.waddr});
        chk("rf_wdata", {32'd0, bus.rf_wdata}, {32'd0, e.wdata});
        chk("instret", bus.instret_o, exp_instret);
        hold_addr = e.waddr; hold_data = e.wdata;
      end
      last_instret = bus.instret_o;
    end else begin
      chk("hold_waddr", {59'd0, bus.rf_waddr}, {59'd0, hold_addr});
      chk("hold_wdata", {32'd0, bus.rf_wdata}, {32'd0, hold_data});
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.alu = '0; bus.csr_rdata = '0; bus.pc = '0; bus.wb_sel = 2'b00;
    bus.reg_wr = 1'b0; bus.rd_addr = '0; bus.load_size = '0; bus.addr_lsb = '0;
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;

    tbl[0] = '{2'b00, 32'h1234_5678, 32'h0BAD_0001, 32'h0000_2000, 32'h0000_0000, 1'b0, 1'b1, 5'd5,  3'd0, 3'd0, 1'b1, 32'h1234_5678};
    tbl[1] = '{2'b10, 32'h1111_1111, 32'h0BAD_0002, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1, 5'd1,  3'd0, 3'd0, 1'b1, 32'h0000_0000};
    tbl[2] = '{2'b11, 32'h2222_2222, 32'hCAFE_F00D, 32'h0000_3000, 32'h0000_0000, 1'b0, 1'b1, 5'd0,  3'd0, 3'd0, 1'b0, 32'hCAFE_F00D};
    tbl[3] = '{2'b00, 32'hDEAD_BEEF, 32'h0BAD_0003, 32'h0000_4000, 32'h0000_0000, 1'b0, 1'b0, 5'd31, 3'd0, 3'd0, 1'b0, 32'hDEAD_BEEF};
    tbl[4] = '{2'b01, 32'h3333_3333, 32'h0BAD_0004, 32'h0000_5000, 32'h8001_0000, 1'b1, 1'b1, 5'd7,  3'b101, 3'd2, 1'b1, LHU_EXP};
    tbl[5] = '{2'b10, 32'h4444_4444, 32'h0BAD_0005, 32'h0000_1000, 32'h0000_0000, 1'b0, 1'b1, 5'd2,  3'd0, 3'd0, 1'b1, 32'h0000_1004};
    tbl[6] = '{2'b01, 32'h5555_5555, 32'h0BAD_0006, 32'h0000_6000, 32'h7F00_0000, 1'b1, 1'b1, 5'd9,  3'b000, 3'd3, 1'b1, LB_EXP};
    tbl[7] = '{2'b11, 32'h6666_6666, 32'h8000_0001, 32'h0000_7000, 32'h0000_0000, 1'b0, 1'b1, 5'd30, 3'd0, 3'd0, 1'b1, 32'h8000_0001};

    repeat (2) @(posedge clk);
    #2;
    chk("rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
    chk("rst_waddr", {59'd0, bus.rf_waddr}, 64'd0);
    chk("rst_wdata", {32'd0, bus.rf_wdata}, 64'd0);
    chk("rst_instret", bus.instret_o, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_stall", {63'd0, bus.stall_o}, 64'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back table vectors, one transfer per cycle.
    for (int unsigned i = 0; i < 8; i++) apply(tbl[i]);
    idle_inputs();
    step();

    // Streaming ALU ops followed by a stray load response in IDLE.
    for (int unsigned i = 0; i < 4; i++)
      apply('{2'b00, 32'hA000_0000 + 32'(i), 32'h0BAD_0100, 32'h0000_8000, 32'h0000_0000,
              1'b0, 1'b1, 5'(10 + i), 3'd0, 3'd0, 1'b1, 32'hA000_0000 + 32'(i)});
    bus.in_valid = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    step();
    step();
    chk("instret_after_stream", bus.instret_o, 64'd12);

    // Delayed LB with in_valid held through the wait.
    bus.wb_sel = 2'b01; bus.reg_wr = 1'b1; bus.rd_addr = 5'd12; bus.load_size = 3'b000;
    bus.addr_lsb = 3'd2; bus.dmem_rdata = 32'h0000_0000; bus.dmem_rvalid = 1'b0; bus.in_valid = 1'b1;
    #1;
    chk("dly_stall_idle", {63'd0, bus.stall_o}, 64'd1);
    chk("dly_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    push(1'b1, 5'd12, DLY_EXP);
    step();
    for (int unsigned i = 0; i < 3; i++) begin
      chk("dly_stall_wait", {63'd0, bus.stall_o}, 64'd1);
      chk("dly_ready_wait", {63'd0, bus.in_ready}, 64'd0);
      step();
    end
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h0080_0000;
    #1;
    chk("dly_stall_resp", {63'd0, bus.stall_o}, 64'd1);
    step();
    idle_inputs();
    step();
    step();

    for (int unsigned i = 0; i < 20 && sbq.size() != 0; i++) step();
    chk("sb_drain", 64'(sbq.size()), 64'd0);
    chk("instret_final", bus.instret_o, 64'd13);

    // Reset while a load is pending: no write may follow.
    bus.wb_sel = 2'b01; bus.rd_addr = 5'd20; bus.reg_wr = 1'b1; bus.in_valid = 1'b1; bus.dmem_rvalid = 1'b0;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_stall", {63'd0, bus.stall_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_we", {63'd0, bus.rf_we}, 64'd0);
    chk("midrst_instret", bus.instret_o, 64'd0);
    chk("midrst_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("midrst_stall", {63'd0, bus.stall_o}, 64'd0);
    step();
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1357_9BDF;
    step();
    idle_inputs();
    step();
    step();
    chk("post_rst_instret", bus.instret_o, 64'd0);
    chk("post_rst_rf_we", {63'd0, bus.rf_we}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_seq.md
# wb_stage_seq

Registered, handshaked write-back stage for the pipelined core, replacing the purely combinational result select. It accepts one retiring instruction per cycle from the memory stage and selects ALU, load, PC+4 or CSR data. It holds loads until the data-memory response arrives, stalling upstream while it waits. It drives a registered register-file write port and a retired-instruction counter.

## Interface
Parameters:
- WIDTH, 32, datapath width; legal values 32 or 64
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  memory stage presents a retiring instruction
- in_ready  out  1  stage can accept this cycle
- alu  in  WIDTH  ALU result
- csr_rdata  in  WIDTH  CSR read data
- pc  in  WIDTH  instruction PC
- wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 CSR
- reg_wr  in  1  instruction writes rd
- rd_addr  in  REG_AW  destination register
- load_size  in  3  load funct3
- addr_lsb  in  3  load byte offset; bit 2 is ignored when WIDTH=32
- dmem_rvalid  in  1  load response valid
- dmem_rdata  in  WIDTH  raw aligned memory word
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  REG_AW  write address (registered)
- rf_wdata  out  WIDTH  write data (registered)
- stall_o  out  1  hold the upstream pipeline
- instret_o  out  64  count of completed instructions

## Operation
- The FSM has two states, IDLE and WAIT_LOAD. Reset enters IDLE.
- in_ready = (state == IDLE).
- A transfer occurs when in_valid && in_ready.
- **IDLE, transfer, wb_sel != 01:** result is registered at the next edge.
  - 00: alu
  - 10: pc+4, wrapping modulo 2^WIDTH
  - 11: csr_rdata
- **IDLE, transfer, wb_sel == 01, dmem_rvalid = 1 in the same cycle:** the load completes like a non-load.
- **IDLE, transfer, wb_sel == 01, dmem_rvalid = 0:**
  - Capture rd_addr, reg_wr, load_size and addr_lsb.
  - Go to WAIT_LOAD.
- **WAIT_LOAD, dmem_rvalid = 1:** apply the load result, register the write, return to IDLE.
- **WAIT_LOAD, dmem_rvalid = 0:** hold. There is no timeout.
- dmem_rvalid in IDLE without an accepted load is ignored.
- **Completion cycle** (next edge):
  - rf_we = reg_wr && (rd_addr != 0).
  - rf_waddr and rf_wdata are loaded.
  - instret_o increments by 1, including for rd = x0 or reg_wr = 0.
- **Non-completion edges:**
  - rf_we = 0.
  - rf_waddr and rf_wdata hold their last values.
- stall_o = (state == WAIT_LOAD) || (IDLE && in_valid && wb_sel == 01 && !dmem_rvalid). This is combinational.
- instret_o wraps from 2^64-1 to 0.

## Timing
- Reset values: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, instret_o 0. in_ready is 1 and stall_o is 0 during reset.
- Reset mid-load drops the pending load. No write occurs.
- Non-load latency: transfer at edge N gives rf_we high for the single cycle after N.
- Load latency: rvalid sampled at edge M gives rf_we high for the cycle after M. With same-cycle rvalid, latency is 1.
- Throughput: one instruction per cycle when no load waits.
- Back-to-back: a transfer in the cycle after completion is accepted, and rf_we stays high on consecutive cycles.

## Configuration
- Macro: WB_LOAD_EXT_EN.
- **Defined:** the load result is dmem_rdata >> (8*offset), then sized and extended by load_size.
  - 000 LB, sign-extended
  - 001 LH, sign-extended
  - 010 LW; sign-extended when WIDTH=64
  - 100 LBU, zero-extended
  - 101 LHU, zero-extended
  - 110 LWU, zero-extended (WIDTH=64)
  - 011 LD (WIDTH=64)
  - Codes illegal for the configured WIDTH pass the shifted word unchanged.
- **Undefined:** the load result is dmem_rdata verbatim. load_size and addr_lsb are ignored, and the memory unit performs the extraction.

## Test plan
- **Reset:** rst_n low mid-WAIT_LOAD -> rf_we 0, instret_o 0, in_ready 1 immediately. No write after release.
- **ALU write:** wb_sel=00, alu=0x1234_5678, rd=5, reg_wr=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678, instret_o=1.
- **PC+4 / CSR / x0:**
  - pc=0xFFFF_FFFC, wb_sel=10 -> rf_wdata=0x0000_0000.
  - wb_sel=11, rd=0 -> rf_we=0, instret_o still increments.
- **Delayed load (WB_LOAD_EXT_EN defined):** LB, addr_lsb=2, rvalid 3 cycles late with dmem_rdata=0x0080_0000.
  - stall_o=1 and in_ready=0 for 3 cycles.
  - Then rf_wdata=0xFFFF_FF80.
  - in_valid held throughout is not double-accepted.
- **Extraction variants:**
  - LHU, offset 2, rdata=0x8001_0000, same-cycle rvalid -> 0x0000_8001 after 1 cycle.
  - Macro undefined, same stimulus -> 0x8001_0000.
- **Streaming:** 4 back-to-back ALU ops, then a spurious dmem_rvalid in IDLE -> 4 consecutive rf_we pulses, instret_o=4, spurious rvalid ignored.
